byte_serializer: RTL and testbench
==================================

# byte_serializer

Transmit-side companion to the serial deserializer. Bytes are accepted on a parallel port into an internal FIFO, then shifted out LSB-first as one data bit plus a write strobe per bit, matching the deserializer's `data_in`/`write_in`/`status_out` protocol. A byte is launched only when the receiver raises its ready status. The block sits in the sending domain of `top` and drives the deserializer's input pins directly.

## Interface
- `DEPTH`, 8: FIFO capacity in bytes (power of two, ≥2).
- `START_DELAY`, 10: cycles from byte launch to first bit strobe (≥1).
- `BIT_HIGH`, 10: cycles `write_out` is high per bit (≥1).
- `BIT_LOW`, 10: cycles `write_out` is low after each strobe (≥1).
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in 8: byte to enqueue.
- `write_in` in 1: enqueue strobe; each cycle high pushes `data_in` once.
- `len_out` out $clog2(DEPTH+1): bytes currently queued, excluding the byte in flight.
- `full_out` out 1: `len_out == DEPTH`.
- `overflow_out` out 1: one-cycle pulse when a push is dropped.
- `status_in` in 1: receiver ready, from the deserializer's `status_out`.
- `data_out` out 1: serial bit to the deserializer's `data_in`.
- `write_out` out 1: bit strobe to the deserializer's `write_in`.
- `busy_out` out 1: high while a byte is in flight.

## Operation
- Reset values: `len_out`=0, `full_out`=0, `overflow_out`=0, `data_out`=0, `write_out`=0, `busy_out`=0. FIFO pointers are 0 and the FSM is in IDLE. Reset mid-byte aborts the transfer and discards all FIFO contents.
- FIFO: circular buffer, read and write pointers wrap modulo DEPTH.
  - Push accepted when `write_in` and not full.
  - Push with full and no pop on the same edge: dropped, contents unchanged, `overflow_out`=1 for one cycle.
  - Push and pop on the same edge, including at full: both happen and `len_out` is unchanged.
- FSM states: IDLE, DELAY, STROBE, GAP.
  - IDLE → DELAY when `len_out>0` and `status_in`=1 are sampled on an edge. On that edge the head byte is popped into the shift register, the bit index is cleared, and `busy_out` goes to 1.
  - DELAY → STROBE after START_DELAY cycles. On entry `data_out` takes bit[idx] and `write_out` goes to 1.
  - STROBE → GAP after BIT_HIGH cycles. On entry `write_out` goes to 0; `data_out` is held.
  - GAP → STROBE (idx+1) after BIT_LOW cycles if idx<7. Otherwise GAP → IDLE, with `data_out` and `busy_out` returning to 0.
- Bit order is LSB first: bit0, then bit1, through bit7.
- `status_in` is sampled only in IDLE. A falling `status_in` mid-byte is ignored and the byte completes.
- Back-to-back bytes: at least one IDLE cycle between bytes; the next launch requires `status_in`=1 again.

## Timing
- Push at edge E: `len_out` and `full_out` update after E.
- Launch at edge E0: first `write_out` rise after edge E0+START_DELAY.
- Bit k strobe: high for edges [E0+START_DELAY+k·(BIT_HIGH+BIT_LOW), +BIT_HIGH).
- `data_out` is stable for the full BIT_HIGH+BIT_LOW window of each bit. It changes only together with a rising `write_out`, or at return to IDLE.
- Byte duration from pop: START_DELAY + 8·(BIT_HIGH+BIT_LOW) cycles (170 with defaults). IDLE is re-entered on the last edge of that window.
- `len_out` decrements at the launch edge E0, not at completion.

## Test plan
- Reset then idle, with `status_in`=1 and an empty FIFO → all outputs 0; `busy_out` never rises.
- Push 0x99 with `status_in`=0 → `len_out`=1 and no strobes. Raise `status_in`:
  - `len_out`→0 and `busy_out`=1 at the next edge.
  - After 10 cycles, 8 strobes each 10 cycles high and 10 cycles low, carrying `data_out` = 1,0,0,1,1,0,0,1.
  - `busy_out` falls 170 cycles after launch.
- Push 9 bytes 0x01..0x09 with `status_in`=0 → `full_out`=1 after the 8th push, the 9th push is dropped, and `overflow_out` pulses once. Raise `status_in` → bytes 0x01..0x08 transmitted in order; `len_out` wraps correctly.
- FIFO full and byte launched on the same edge as a push of 0xA5 → `len_out` stays 8, no overflow, and 0xA5 is transmitted last.
- Drop `status_in` during bit 3 → the byte completes. The next byte waits until `status_in` is high again in IDLE.
- Assert `reset` during bit 5 → `write_out`, `data_out`, `busy_out` and `len_out` are 0 after the edge; no further strobes.

Source files
------------

// File: rtl/byte_serializer.sv
// Byte FIFO feeding an LSB-first bit serializer that drives the deserializer's
// data_in/write_in pins, launching each byte only when the receiver reports ready.
module byte_serializer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned START_DELAY = 10,
    parameter int unsigned BIT_HIGH    = 10,
    parameter int unsigned BIT_LOW     = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   data_in,
    input  logic                         write_in,
    output logic [$clog2(DEPTH+1)-1:0]   len_out,
    output logic                         full_out,
    output logic                         overflow_out,
    input  logic                         status_in,
    output logic                         data_out,
    output logic                         write_out,
    output logic                         busy_out
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned LW   = $clog2(DEPTH + 1);
    localparam int unsigned TM0  = (START_DELAY > BIT_HIGH) ? START_DELAY : BIT_HIGH;
    localparam int unsigned TMAX = (TM0 > BIT_LOW) ? TM0 : BIT_LOW;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        STROBE,
        GAP
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          data_q, data_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;

    logic full;
    logic pop;
    logic push;

    // A pop frees a slot on the same edge, so a push at full still lands.
    always_comb begin
        full       = (count_q == LW'(DEPTH));
        pop        = (state_q == IDLE) && (count_q != '0) && status_in;
        push       = write_in && (!full || pop);
        overflow_d = write_in && full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pop) begin
                    state_d = DELAY;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            DELAY: begin
                if (timer_q == TW'(START_DELAY - 1)) begin
                    state_d = STROBE;
                    timer_d = '0;
                    data_d  = shift_q[idx_q];
                    wr_d    = 1'b1;
                end
            end
            STROBE: begin
                if (timer_q == TW'(BIT_HIGH - 1)) begin
                    state_d = GAP;
                    timer_d = '0;
                    wr_d    = 1'b0;
                end
            end
            GAP: begin
                if (timer_q == TW'(BIT_LOW - 1)) begin
                    timer_d = '0;
                    if (idx_q != 3'd7) begin
                        state_d = STROBE;
                        idx_d   = idx_q + 3'd1;
                        data_d  = shift_q[idx_q + 3'd1];
                        wr_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        data_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                data_d  = 1'b0;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
        end
    end

    assign len_out      = count_q;
    assign full_out     = full;
    assign overflow_out = overflow_q;
    assign data_out     = data_q;
    assign write_out    = wr_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench for byte_serializer: bytes queued at push time are matched
// against bytes reassembled from the serial strobes.
module tb_byte_serializer;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned SD       = 10;
    localparam int unsigned BH       = 10;
    localparam int unsigned BL       = 10;
    localparam int unsigned LW       = $clog2(DEPTH + 1);
    localparam int unsigned BYTE_CYC = SD + 8 * (BH + BL);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          write_in = 1'b0;
    logic [LW-1:0] len_out;
    logic          full_out;
    logic          overflow_out;
    logic          status_in = 1'b0;
    logic          data_out;
    logic          write_out;
    logic          busy_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    byte_serializer #(
        .DEPTH      (DEPTH),
        .START_DELAY(SD),
        .BIT_HIGH   (BH),
        .BIT_LOW    (BL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .write_in    (write_in),
        .len_out     (len_out),
        .full_out    (full_out),
        .overflow_out(overflow_out),
        .status_in   (status_in),
        .data_out    (data_out),
        .write_out   (write_out),
        .busy_out    (busy_out)
    );

    always #5 clock = ~clock;

    int unsigned nbits = 0;
    int unsigned hi = 0;
    logic prev_w = 1'b0;
    logic cur_bit = 1'b0;
    logic [7:0] rx = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clock) begin
        if (reset) begin
            nbits  = 0;
            hi     = 0;
            prev_w = 1'b0;
        end else begin
            if (write_out && !prev_w) begin
                cur_bit = data_out;
                rx[nbits[2:0]] = data_out;
                hi = 1;
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_byte: got %02h, expected no byte", rx);
                    end else begin
                        exp_b = sb.pop_front();
                        if (rx !== exp_b) begin
                            n_err++;
                            $display("FAIL rx_byte: got %02h, expected %02h", rx, exp_b);
                        end
                    end
                end
            end else if (write_out) begin
                hi++;
            end else if (prev_w) begin
                n_cmp++;
                if (hi != BH) begin
                    n_err++;
                    $display("FAIL strobe_width: got %0d, expected %0d", hi, BH);
                end
                n_cmp++;
                if (data_out !== cur_bit) begin
                    n_err++;
                    $display("FAIL data_hold: got %b, expected %b", data_out, cur_bit);
                end
            end
            prev_w = write_out;
        end
    end

    task automatic test_reset();
        logic seen;
        reset = 1'b1; status_in = 1'b1; write_in = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({len_out, full_out, overflow_out, data_out, write_out, busy_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got len=%0d full=%b ovf=%b d=%b w=%b busy=%b, expected all 0",
                     len_out, full_out, overflow_out, data_out, write_out, busy_out);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (busy_out !== 1'b0 || write_out !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL idle_empty: got activity=%b, expected 0", seen);
        end
        status_in = 1'b0;
    endtask

    task automatic test_single();
        int c;
        int first;
        data_in = 8'h99; write_in = 1'b1;
        sb.push_back(8'h99);
        @(negedge clock);
        write_in = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (len_out !== LW'(1) || write_out !== 1'b0 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL hold_not_ready: got len=%0d w=%b busy=%b, expected 1/0/0", len_out, write_out, busy_out);
        end
        status_in = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (len_out !== LW'(0) || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL launch: got len=%0d busy=%b, expected 0/1", len_out, busy_out);
        end
        c = 0; first = -1;
        while (busy_out === 1'b1 && c < 400) begin
            @(negedge clock);
            c++;
            if (write_out === 1'b1 && first < 0) first = c;
        end
        n_cmp++;
        if (first != int'(SD)) begin
            n_err++;
            $display("FAIL first_strobe: got %0d, expected %0d", first, SD);
        end
        n_cmp++;
        if (c != int'(BYTE_CYC)) begin
            n_err++;
            $display("FAIL byte_duration: got %0d, expected %0d", c, BYTE_CYC);
        end
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++;
            $display("FAIL idle_data: got %b, expected 0", data_out);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL single_drain: got %0d pending, expected 0", sb.size());
        end
        status_in = 1'b0;
    endtask

    task automatic test_overflow();
        int c;
        int launches;
        int exp_len;
        logic prev_busy;
        int ovf_cnt;
        ovf_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            data_in = 8'(k); write_in = 1'b1;
            if (k <= 8) sb.push_back(8'(k));
            @(negedge clock);
            if (overflow_out === 1'b1) ovf_cnt++;
            n_cmp++;
            if (k <= 8) begin
                if (len_out !== LW'(k) || full_out !== (k == 8)) begin
                    n_err++;
                    $display("FAIL fill_%0d: got len=%0d full=%b, expected %0d/%b", k, len_out, full_out, k, (k == 8));
                end
            end else if (len_out !== LW'(8) || overflow_out !== 1'b1) begin
                n_err++;
                $display("FAIL overflow_drop: got len=%0d ovf=%b, expected 8/1", len_out, overflow_out);
            end
        end
        write_in = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (overflow_out === 1'b1) ovf_cnt++;
        end
        n_cmp++;
        if (ovf_cnt != 1) begin
            n_err++;
            $display("FAIL overflow_pulses: got %0d, expected 1", ovf_cnt);
        end
        status_in = 1'b1;
        c = 0; launches = 0; exp_len = 7; prev_busy = 1'b0;
        while ((busy_out !== 1'b0 || sb.size() != 0 || len_out !== LW'(0) || c == 0) && c < 3000) begin
            @(negedge clock);
            c++;
            if (busy_out === 1'b1 && prev_busy === 1'b0) begin
                launches++;
                n_cmp++;
                if (len_out !== LW'(exp_len)) begin
                    n_err++;
                    $display("FAIL len_after_launch: got %0d, expected %0d", len_out, exp_len);
                end
                exp_len--;
            end
            prev_busy = busy_out;
        end
        n_cmp++;
        if (launches != 8 || sb.size() != 0 || c >= 3000) begin
            n_err++;
            $display("FAIL overflow_drain: got launches=%0d pending=%0d cycles=%0d, expected 8/0/<3000",
                     launches, sb.size(), c);
        end
        status_in = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int c;
        for (int k = 0; k < 8; k++) begin
            data_in = 8'h10 + 8'(k); write_in = 1'b1;
            sb.push_back(8'h10 + 8'(k));
            @(negedge clock);
        end
        write_in = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (full_out !== 1'b1) begin
            n_err++;
            $display("FAIL refill_full: got %b, expected 1", full_out);
        end
        data_in = 8'hA5; write_in = 1'b1; status_in = 1'b1;
        sb.push_back(8'hA5);
        @(negedge clock);
        write_in = 1'b0;
        n_cmp++;
        if (len_out !== LW'(8) || overflow_out !== 1'b0 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL push_pop_full: got len=%0d ovf=%b busy=%b, expected 8/0/1", len_out, overflow_out, busy_out);
        end
        c = 0;
        while ((busy_out !== 1'b0 || sb.size() != 0 || len_out !== LW'(0)) && c < 3000) begin
            @(negedge clock);
            c++;
        end
        n_cmp++;
        if (sb.size() != 0 || c >= 3000) begin
            n_err++;
            $display("FAIL push_pop_drain: got pending=%0d cycles=%0d, expected 0/<3000", sb.size(), c);
        end
        status_in = 1'b0;
    endtask

    task automatic test_status_drop();
        int c;
        logic seen;
        data_in = 8'h3C; write_in = 1'b1; sb.push_back(8'h3C);
        @(negedge clock);
        data_in = 8'hC3; sb.push_back(8'hC3);
        @(negedge clock);
        write_in = 1'b0;
        status_in = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL drop_launch: got busy=%b, expected 1", busy_out);
        end
        repeat (SD + 3 * (BH + BL) + 2) @(negedge clock);
        n_cmp++;
        if (write_out !== 1'b1) begin
            n_err++;
            $display("FAIL bit3_strobe: got w=%b, expected 1", write_out);
        end
        status_in = 1'b0;
        c = 0;
        while (busy_out === 1'b1 && c < 200) begin
            @(negedge clock);
            c++;
        end
        n_cmp++;
        if (busy_out !== 1'b0 || sb.size() != 1) begin
            n_err++;
            $display("FAIL drop_complete: got busy=%b pending=%0d, expected 0/1", busy_out, sb.size());
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (busy_out !== 1'b0 || write_out !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || len_out !== LW'(1)) begin
            n_err++;
            $display("FAIL wait_ready: got activity=%b len=%0d, expected 0/1", seen, len_out);
        end
        status_in = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (busy_out !== 1'b1 || len_out !== LW'(0)) begin
            n_err++;
            $display("FAIL relaunch: got busy=%b len=%0d, expected 1/0", busy_out, len_out);
        end
        c = 0;
        while (busy_out === 1'b1 && c < 300) begin
            @(negedge clock);
            c++;
        end
        n_cmp++;
        if (sb.size() != 0 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL drop_drain: got pending=%0d busy=%b, expected 0/0", sb.size(), busy_out);
        end
        status_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        data_in = 8'h7A; write_in = 1'b1; sb.push_back(8'h7A);
        @(negedge clock);
        data_in = 8'h77;
        @(negedge clock);
        write_in = 1'b0;
        status_in = 1'b1;
        @(negedge clock);
        repeat (SD + 5 * (BH + BL) + 2) @(negedge clock);
        n_cmp++;
        if (write_out !== 1'b1 || data_out !== 1'b1) begin
            n_err++;
            $display("FAIL bit5_strobe: got w=%b d=%b, expected 1/1", write_out, data_out);
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (write_out !== 1'b0 || data_out !== 1'b0 || busy_out !== 1'b0 || len_out !== LW'(0)) begin
            n_err++;
            $display("FAIL mid_reset: got w=%b d=%b busy=%b len=%0d, expected all 0",
                     write_out, data_out, busy_out, len_out);
        end
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        seen = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (write_out !== 1'b0 || busy_out !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got activity=%b, expected 0", seen);
        end
        status_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_status_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
